// File: rtl/arbitro_escrita_registro_pkg.sv
// -----------------------------------------------------------------------------
// pkg_banco
// Shared types and sizes for the 8x16 register bank write-port controller.
// Contents:
//   BITS_PALAVRA   data word width
//   END_REGISTROS  register address width
//   NUM_REGISTROS  number of registers swept by the clear sequence
//   estado_t       controller state (LIMPA = clearing, ATIVO = arbitrating)
//   palavra_t      one data word
//   end_reg_t      one register address
// -----------------------------------------------------------------------------
package pkg_banco;

  localparam int BITS_PALAVRA  = 16;
  localparam int END_REGISTROS = 3;
  localparam int NUM_REGISTROS = 2 ** END_REGISTROS;

  typedef enum logic {
    LIMPA,
    ATIVO
  } estado_t;

  typedef logic [BITS_PALAVRA-1:0]  palavra_t;
  typedef logic [END_REGISTROS-1:0] end_reg_t;

endpackage

// File: rtl/arbitro_escrita_registro_if.sv
// -----------------------------------------------------------------------------
// arbitro_escrita_registro_if
// Bundles the requester handshake and the bank write port of the write-port
// controller. Clock and reset are kept outside as plain ports.
// Signals:
//   limpa       single-cycle pulse requesting a clear sweep
//   req_valid   per-requester pending write
//   req_end     packed destination addresses (slice i = requester i)
//   req_dado    packed write data (slice i = requester i)
//   req_ready   one-hot grant (combinational)
//   Hab_Escrita bank write enable (registered)
//   Sel_E_SA    bank write address (registered)
//   E           bank write data (registered)
//   ocupado     high while a clear sweep is running (registered)
// Modports:
//   master  requester / environment side
//   slave   controller side
// -----------------------------------------------------------------------------
interface arbitro_escrita_registro_if #(
  parameter int N_REQ = 3
);
  import pkg_banco::*;

  logic                            limpa;
  logic [N_REQ-1:0]                req_valid;
  logic [N_REQ*END_REGISTROS-1:0]  req_end;
  logic [N_REQ*BITS_PALAVRA-1:0]   req_dado;
  logic [N_REQ-1:0]                req_ready;
  logic                            Hab_Escrita;
  end_reg_t                        Sel_E_SA;
  palavra_t                        E;
  logic                            ocupado;

  modport master (
    output limpa,
    output req_valid,
    output req_end,
    output req_dado,
    input  req_ready,
    input  Hab_Escrita,
    input  Sel_E_SA,
    input  E,
    input  ocupado
  );

  modport slave (
    input  limpa,
    input  req_valid,
    input  req_end,
    input  req_dado,
    output req_ready,
    output Hab_Escrita,
    output Sel_E_SA,
    output E,
    output ocupado
  );

endinterface

// File: rtl/arbitro_escrita_registro_rr_arbitro.sv
// -----------------------------------------------------------------------------
// rr_arbitro
// Purely combinational round-robin priority picker. Starting at position ptr
// and moving upward modulo N_REQ, the first asserted request wins.
// Ports:
//   req    in   N_REQ          request vector
//   ptr    in   clog2(N_REQ)   highest-priority position this cycle
//   grant  out  N_REQ          one-hot winner (all zero when no request)
//   idx    out  clog2(N_REQ)   index of the winner (0 when no request)
//   any    out  1              at least one request is asserted
// -----------------------------------------------------------------------------
module rr_arbitro #(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     any
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] cand_idx;

  // Walk the N_REQ positions in priority order (ptr, ptr+1, ... wrapping) and
  // latch onto the first one that is requesting; later hits are ignored.
  always_comb begin
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    cand_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_idx = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        idx             = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_escrita_registro.sv
// -----------------------------------------------------------------------------
// arbitro_escrita_registro
// Write-port controller for the 8x16 register bank. Round-robin arbitrates
// N_REQ writeback requesters onto the single bank write port, and runs a clear
// sweep that writes zero to every register after reset or on a limpa pulse.
// All bank-side outputs are registered so they are stable for the bank's
// negedge write.
// Ports:
//   clock  in   1   rising-edge clock
//   reset  in   1   synchronous, active-high
//   bus    slave modport of arbitro_escrita_registro_if:
//            limpa, req_valid, req_end, req_dado        (in)
//            req_ready, Hab_Escrita, Sel_E_SA, E, ocupado (out)
// -----------------------------------------------------------------------------
module arbitro_escrita_registro
  import pkg_banco::*;
#(
  parameter int N_REQ = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  arbitro_escrita_registro_if.slave   bus
);

  localparam int PTR_W = $clog2(N_REQ);

  estado_t           state_q, state_d;
  end_reg_t          cnt_q, cnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              hab_q, hab_d;
  end_reg_t          sel_q, sel_d;
  palavra_t          e_q, e_d;
  logic              ocupado_q, ocupado_d;
  logic [N_REQ-1:0]  ready;

  logic [N_REQ-1:0]  grant;
  logic [PTR_W-1:0]  idx;
  logic              any;

  end_reg_t          end_sel;
  palavra_t          dado_sel;

  rr_arbitro #(
    .N_REQ (N_REQ)
  ) u_rr_arbitro (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (idx),
    .any   (any)
  );

  // Select the address/data slice of whichever requester the arbiter picked.
  always_comb begin
    end_sel  = '0;
    dado_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        end_sel  = bus.req_end[i*END_REGISTROS +: END_REGISTROS];
        dado_sel = bus.req_dado[i*BITS_PALAVRA +: BITS_PALAVRA];
      end
    end
  end

  // Next-state and grant logic. Hab_Escrita defaults low so every write is a
  // single-cycle pulse; address and data hold their last value when idle.
  // A limpa pulse during a sweep only rewinds the counter: that cycle issues
  // no write and the following cycle starts again at register 0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    hab_d     = 1'b0;
    sel_d     = sel_q;
    e_d       = e_q;
    ocupado_d = ocupado_q;
    ready     = '0;

    unique case (state_q)
      LIMPA: begin
        if (bus.limpa) begin
          cnt_d = '0;
        end else begin
          hab_d = 1'b1;
          sel_d = cnt_q;
          e_d   = '0;
          if (cnt_q == end_reg_t'(NUM_REGISTROS - 1)) begin
            state_d   = ATIVO;
            cnt_d     = '0;
            ocupado_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ATIVO: begin
        if (bus.limpa) begin
          state_d   = LIMPA;
          cnt_d     = '0;
          ocupado_d = 1'b1;
        end else if (any) begin
          ready = grant;
          hab_d = 1'b1;
          sel_d = end_sel;
          e_d   = dado_sel;
          if (idx == PTR_W'(N_REQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = idx + 1'b1;
          end
        end
      end

      default: begin
        state_d = LIMPA;
      end
    endcase

    // No grant may be issued in a reset cycle: the accept would be lost.
    if (reset) begin
      ready = '0;
    end
  end

  // State and output registers with synchronous reset into a fresh sweep.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= LIMPA;
      cnt_q     <= '0;
      ptr_q     <= '0;
      hab_q     <= 1'b0;
      sel_q     <= '0;
      e_q       <= '0;
      ocupado_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      hab_q     <= hab_d;
      sel_q     <= sel_d;
      e_q       <= e_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign bus.req_ready   = ready;
  assign bus.Hab_Escrita = hab_q;
  assign bus.Sel_E_SA    = sel_q;
  assign bus.E           = e_q;
  assign bus.ocupado     = ocupado_q;

endmodule

// File: tb/tb_arbitro_escrita_registro.sv
// -----------------------------------------------------------------------------
// tb_arbitro_escrita_registro
// Self-checking bench for arbitro_escrita_registro. A behavioural model turns
// each cycle's stimulus into the expected grant and expected bank write; the
// writes are queued and a separate monitor compares them against the bank port.
// -----------------------------------------------------------------------------
module tb_arbitro_escrita_registro;
  import pkg_banco::*;

  localparam int N = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;

  arbitro_escrita_registro_if #(.N_REQ(N)) bus ();

  arbitro_escrita_registro #(.N_REQ(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  bit  mon_en = 1'b0;

  // Reference model state: sweep in progress, next register to clear,
  // round-robin start position, and last address/data sent to the bank.
  bit             m_clearing;
  int             m_next;
  int             m_ptr;
  int             m_sel;
  int             m_e;
  logic [N-1:0]   m_ready;

  // Requester-side pending requests, held until granted.
  logic [N-1:0]   p_v;
  int             p_e[N];
  int             p_d[N];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of the reference behaviour, written from the rules: reset starts
  // a sweep, a sweep writes zero to registers 0..NUM_REGISTROS-1, limpa starts
  // (or rewinds) a sweep, otherwise the first valid requester from ptr upward wins.
  function automatic void modelStep(input bit rst, input bit lim);
    wr_t w;
    int  c;
    m_ready = '0;
    if (rst) begin
      m_clearing = 1'b1;
      m_next     = 0;
      m_ptr      = 0;
      m_sel      = 0;
      m_e        = 0;
    end else if (m_clearing) begin
      if (lim) begin
        m_next = 0;
      end else begin
        w.addr = m_next;
        w.data = 0;
        exp_q.push_back(w);
        m_sel = m_next;
        m_e   = 0;
        m_next++;
        if (m_next == NUM_REGISTROS) begin
          m_clearing = 1'b0;
          m_next     = 0;
        end
      end
    end else if (lim) begin
      m_clearing = 1'b1;
      m_next     = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (p_v[c]) begin
          m_ready[c] = 1'b1;
          w.addr = p_e[c];
          w.data = p_d[c];
          exp_q.push_back(w);
          m_sel = p_e[c];
          m_e   = p_d[c];
          m_ptr = (c + 1) % N;
          break;
        end
      end
    end
  endfunction

  // Drive one cycle of inputs at the falling edge, check the combinational
  // grant, then check the registered status just after the rising edge.
  task automatic applyStimulus(input bit rst, input bit lim);
    @(negedge clock);
    reset         = rst;
    bus.limpa     = lim;
    bus.req_valid = p_v;
    for (int i = 0; i < N; i++) begin
      bus.req_end[i*END_REGISTROS +: END_REGISTROS] = END_REGISTROS'(p_e[i]);
      bus.req_dado[i*BITS_PALAVRA +: BITS_PALAVRA]  = BITS_PALAVRA'(p_d[i]);
    end
    #1;
    modelStep(rst, lim);
    checkOutput("req_ready", 32'(bus.req_ready), 32'(m_ready));
    for (int i = 0; i < N; i++) begin
      if (m_ready[i]) p_v[i] = 1'b0;
    end
    @(posedge clock);
    #1;
    checkOutput("ocupado", 32'(bus.ocupado), 32'(m_clearing));
    checkOutput("Sel_E_SA_hold", 32'(bus.Sel_E_SA), 32'(m_sel));
    checkOutput("E_hold", 32'(bus.E), 32'(m_e));
  endtask

  task automatic setReq(input int i, input int e, input int d);
    p_v[i] = 1'b1;
    p_e[i] = e;
    p_d[i] = d;
  endtask

  // Scoreboard monitor: every cycle either the oldest expected write must be
  // on the bank port, or the write enable must be low.
  always begin : monitor
    wr_t w;
    @(posedge clock);
    #2;
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        checkOutput("Hab_Escrita", 32'(bus.Hab_Escrita), 32'd1);
        checkOutput("Sel_E_SA", 32'(bus.Sel_E_SA), 32'(w.addr));
        checkOutput("E", 32'(bus.E), 32'(w.data));
      end else begin
        checkOutput("Hab_Escrita_idle", 32'(bus.Hab_Escrita), 32'd0);
      end
    end
  end

  initial begin
    bus.limpa     = 1'b0;
    bus.req_valid = '0;
    bus.req_end   = '0;
    bus.req_dado  = '0;
    p_v = '0;
    for (int i = 0; i < N; i++) begin
      p_e[i] = 0;
      p_d[i] = 0;
    end

    // Reset, then the 8-register zero sweep and a couple of idle cycles.
    applyStimulus(1'b1, 1'b0);
    mon_en = 1'b1;
    for (int n = 0; n < 10; n++) applyStimulus(1'b0, 1'b0);

    // Single requester 1.
    setReq(1, 5, 16'hBEEF);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);

    // Move the pointer back to 0, then all three held valid for 6 cycles.
    setReq(2, 1, 16'h0222);
    applyStimulus(1'b0, 1'b0);
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!p_v[i]) setReq(i, (n + i) % 8, 16'hA000 + n * 16 + i);
      end
      applyStimulus(1'b0, 1'b0);
    end
    p_v = '0;
    applyStimulus(1'b0, 1'b0);

    // limpa while requester 0 is waiting; it must be served after the sweep.
    setReq(0, 6, 16'h1234);
    applyStimulus(1'b0, 1'b1);
    for (int n = 0; n < 10; n++) applyStimulus(1'b0, 1'b0);

    // Reset in the middle of a sweep.
    applyStimulus(1'b1, 1'b0);
    for (int n = 0; n < 4; n++) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    for (int n = 0; n < 9; n++) applyStimulus(1'b0, 1'b0);

    // Two requesters writing the same address.
    setReq(0, 3, 16'h1111);
    setReq(2, 3, 16'h2222);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);

    // Randomised traffic with occasional withdrawals, limpa pulses and resets.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!p_v[i] && ($urandom_range(0, 2) != 0)) begin
          setReq(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 16'hFFFF)));
        end else if (p_v[i] && ($urandom_range(0, 15) == 0)) begin
          p_v[i] = 1'b0;
        end
      end
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0);
    end

    // Drain and make sure no expected write was left unseen.
    p_v = '0;
    for (int n = 0; n < 12; n++) applyStimulus(1'b0, 1'b0);
    #3;
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
